// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream bridge: uart_mem register map,
// STATUS bit positions and the bridge FSM encoding.
package uart_pkg;

  localparam logic [31:0] REG_BAUD_LO = 32'h0000_0000;
  localparam logic [31:0] REG_BAUD_HI = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS  = 32'h0000_0008;
  localparam logic [31:0] REG_DATA    = 32'h0000_000C;
  localparam logic [31:0] REG_CTRL    = 32'h0000_0010;
  localparam logic [31:0] REG_IRQ     = 32'h0000_0014;

  localparam int STATUS_RX_AVAIL_BIT = 0;
  localparam int STATUS_TX_FULL_BIT  = 1;

  typedef enum logic [2:0] {
    S_INIT_L  = 3'd0,
    S_INIT_H  = 3'd1,
    S_WAIT    = 3'd2,
    S_POLL    = 3'd3,
    S_RD_DATA = 3'd4,
    S_WR_DATA = 3'd5,
    S_HALT    = 3'd6
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with occupancy count; a push is accepted when
// full only if a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is not reset; only pointers and count define validity, and
  // leaving the array out of reset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Bus master that initialises a uart_mem block, then polls STATUS and moves
// bytes between valid/ready streams and the UART DATA register.
module uart_stream_bridge
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000,
  parameter logic [15:0] BAUD_DIV    = 16'd434,
  parameter int          TX_FULL_BIT = 1,
  parameter int          POLL_GAP    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        bus_enable,
  output logic        bus_wr_en,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        err,
  output logic        init_done
);

  state_t      state;
  state_t      next_state;
  logic        gap;
  logic [7:0]  wait_cnt;
  logic        xfer_done;
  logic        ok_done;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        fifo_pop;
  logic        access;
  logic        is_write;
  logic [31:0] offset;
  logic [7:0]  wbyte;
  logic        unused_rdata;

  assign unused_rdata = ^bus_rdata[31:8];

  assign xfer_done = bus_enable && bus_ready;
  assign ok_done   = xfer_done && !bus_err;
  assign fifo_pop  = (state == S_WR_DATA) && ok_done;
  assign tx_ready  = init_done && !fifo_full;

  byte_fifo #(.DEPTH(4)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT_L;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT_L:  if (xfer_done) next_state = bus_err ? S_HALT : S_INIT_H;
      S_INIT_H:  if (xfer_done) next_state = bus_err ? S_HALT : S_WAIT;
      S_WAIT:    if (wait_cnt == 8'(POLL_GAP - 1)) next_state = S_POLL;
      S_POLL: begin
        if (xfer_done) begin
          if (bus_err)
            next_state = S_HALT;
          else if (bus_rdata[STATUS_RX_AVAIL_BIT] && !rx_valid)
            next_state = S_RD_DATA;
          else if (!fifo_empty && !bus_rdata[TX_FULL_BIT])
            next_state = S_WR_DATA;
          else
            next_state = S_WAIT;
        end
      end
      S_RD_DATA, S_WR_DATA: if (xfer_done) next_state = bus_err ? S_HALT : S_WAIT;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_INIT_L;
    endcase
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    access     = 1'b0;
    is_write   = 1'b0;
    offset     = '0;
    wbyte      = '0;
    bus_enable = 1'b0;
    bus_wr_en  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_be     = '0;
    case (state)
      S_INIT_L:  begin access = 1'b1; is_write = 1'b1; offset = REG_BAUD_LO; wbyte = BAUD_DIV[7:0];  end
      S_INIT_H:  begin access = 1'b1; is_write = 1'b1; offset = REG_BAUD_HI; wbyte = BAUD_DIV[15:8]; end
      S_POLL:    begin access = 1'b1; offset = REG_STATUS; end
      S_RD_DATA: begin access = 1'b1; offset = REG_DATA; end
      S_WR_DATA: begin access = 1'b1; is_write = 1'b1; offset = REG_DATA; wbyte = fifo_head; end
      default:   access = 1'b0;
    endcase
    if (access && !gap) begin
      bus_enable = 1'b1;
      bus_wr_en  = is_write;
      bus_addr   = BASE_ADDR + offset;
      bus_wdata  = {24'h0, wbyte};
      bus_be     = 4'b0001;
    end
  end

  // gap resets high so the request stays low during reset and for one cycle
  // after release; it also forces the idle cycle after every completed access.
  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values seen before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap       <= 1'b1;
      wait_cnt  <= '0;
      err       <= 1'b0;
      init_done <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      gap      <= xfer_done;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (xfer_done && bus_err) err <= 1'b1;
      if ((state == S_INIT_H) && ok_done) init_done <= 1'b1;
      if ((state == S_RD_DATA) && ok_done) begin
        rx_valid <= 1'b1;
        rx_data  <= bus_rdata[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge with a behavioural uart_mem slave whose
// DATA writes loop straight back as received bytes.
module tb_uart_stream_bridge;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        bus_enable, bus_wr_en;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;
  logic        err, init_done;

  uart_stream_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .bus_enable(bus_enable), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .err(err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } xact_t;

  xact_t      log_q[$];
  logic [7:0] loop_q[$];
  logic [7:0] wr_data_q[$];
  int         rd_data_cnt = 0;
  logic       force_tx_full = 1'b0;
  logic       inject_err = 1'b0;
  int         lat = 0;
  int         unstable = 0;
  logic [31:0] held_addr, held_wdata;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_mem slave: answers on the third enabled cycle, driven on negedges
  task automatic respond();
    xact_t x;
    x.wr = bus_wr_en; x.addr = bus_addr; x.data = bus_wdata; x.be = bus_be;
    log_q.push_back(x);
    bus_ready = 1'b1;
    bus_rdata = '0;
    if (!bus_wr_en && bus_addr == REG_STATUS) begin
      bus_rdata[STATUS_RX_AVAIL_BIT] = (loop_q.size() != 0);
      bus_rdata[STATUS_TX_FULL_BIT]  = force_tx_full;
    end else if (!bus_wr_en && bus_addr == REG_DATA) begin
      rd_data_cnt++;
      if (loop_q.size() != 0) bus_rdata = {24'h0, loop_q.pop_front()};
    end else if (bus_wr_en && bus_addr == REG_DATA) begin
      if (inject_err) bus_err = 1'b1;
      else begin
        loop_q.push_back(bus_wdata[7:0]);
        wr_data_q.push_back(bus_wdata[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus_ready) begin
      bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0; lat = 0;
    end else if (bus_enable) begin
      lat++;
      if (lat == 1) begin
        held_addr = bus_addr; held_wdata = bus_wdata;
      end else if (bus_addr !== held_addr || bus_wdata !== held_wdata) begin
        unstable++;
      end
      if (lat == 3) respond();
    end else begin
      lat = 0;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    bit done = 1'b0;
    tx_valid = 1'b1; tx_data = d;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (tx_ready) done = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("push_accept", 32'(done), 32'd1);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string tag);
    for (int i = 0; i < 16 * 434 && !rx_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    for (int i = 0; i < 500 && log_q.size() < n; i++) @(negedge clk);
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_init_seq(input string tag);
    wait_log(2, {tag, "_log"});
    check({tag, "_lo_wr"},   32'(log_q[0].wr),  32'd1);
    check({tag, "_lo_addr"}, log_q[0].addr,     32'h0);
    check({tag, "_lo_data"}, log_q[0].data,     32'hB2);
    check({tag, "_lo_be"},   32'(log_q[0].be),  32'h1);
    check({tag, "_hi_addr"}, log_q[1].addr,     32'h4);
    check({tag, "_hi_data"}, log_q[1].data,     32'h01);
  endtask

  initial begin
    logic [7:0] exp5 [5];
    int en_cnt;
    exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_bus_enable", 32'(bus_enable), 0);
    check("rst_bus_wr_en",  32'(bus_wr_en), 0);
    check("rst_bus_addr",   bus_addr, 0);
    check("rst_bus_wdata",  bus_wdata, 0);
    check("rst_bus_be",     32'(bus_be), 0);
    check("rst_tx_ready",   32'(tx_ready), 0);
    check("rst_rx_valid",   32'(rx_valid), 0);
    check("rst_rx_data",    32'(rx_data), 0);
    check("rst_err",        32'(err), 0);
    check("rst_init_done",  32'(init_done), 0);

    // init sequence, then first STATUS read
    rst_n = 1'b1;
    @(negedge clk);
    check("tx_ready_before_init", 32'(tx_ready), 0);
    check_init_seq("init");
    wait_log(3, "first_poll_log");
    check("first_poll_rd",   32'(log_q[2].wr), 0);
    check("first_poll_addr", log_q[2].addr, 32'h8);
    check("init_done_set",   32'(init_done), 1);

    // single byte loopback
    push_byte(8'hAA);
    recv_byte(8'hAA, "loop_aa");
    check("loop_aa_writes", 32'(wr_data_q.size()), 1);
    check("loop_aa_wdata",  32'(wr_data_q[0]), 32'hAA);

    // five bytes back-to-back; UART reports TX full while the FIFO fills
    wr_data_q.delete();
    force_tx_full = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    check("full_after_4", 32'(tx_ready), 0);
    check("no_write_while_uart_full", 32'(wr_data_q.size()), 0);
    force_tx_full = 1'b0;
    push_byte(8'h55);
    for (int i = 0; i < 5; i++) recv_byte(exp5[i], $sformatf("burst%0d", i));
    check("burst_writes", 32'(wr_data_q.size()), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("burst_order%0d", i), 32'(wr_data_q[i]), 32'(exp5[i]));

    // RX back-pressure: second byte stays in the UART until the slot drains
    rd_data_cnt = 0;
    push_byte(8'h66); push_byte(8'h77);
    for (int i = 0; i < 2000 && !(rx_valid && loop_q.size() != 0); i++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("bp_rx_valid", 32'(rx_valid), 1);
    check("bp_rx_data",  32'(rx_data), 32'h66);
    check("bp_data_reads", 32'(rd_data_cnt), 1);
    check("bp_pending",  32'(loop_q.size()), 1);
    recv_byte(8'h66, "bp_first");
    recv_byte(8'h77, "bp_second");
    check("bp_data_reads_after", 32'(rd_data_cnt), 2);

    // bus error on a DATA write halts the bridge and keeps the byte
    inject_err = 1'b1;
    push_byte(8'h5A);
    for (int i = 0; i < 2000 && !err; i++) @(negedge clk);
    check("err_set", 32'(err), 1);
    en_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_enable) en_cnt++;
    end
    check("halt_no_bus", 32'(en_cnt), 0);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    check("fifo_retained", 32'(tx_ready), 0);
    check("halt_no_rx", 32'(rx_valid), 0);

    // reset in the middle of a transfer
    inject_err = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_err_clear", 32'(err), 0);
    rst_n = 1'b1;
    log_q.delete();
    for (int i = 0; i < 100 && !bus_enable; i++) @(negedge clk);
    check("rst3_enable_seen", 32'(bus_enable), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_enable", 32'(bus_enable), 0);
    check("rst_mid_init_done", 32'(init_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    check_init_seq("reinit");

    check("bus_stable", 32'(unstable), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
